// File: rtl/cacc_accu_rmw_if.sv
// Bus bundle for the CACC accumulate read-modify-write block: input beats,
// accumulator RAM ports, completed-sum output stream and saturation count.
interface cacc_accu_rmw_if #(
    parameter int LANES  = 16,
    parameter int LANE_W = 34,
    parameter int AW     = 5
);
    localparam int DW = LANES * LANE_W;

    logic          in_valid;
    logic          in_ready;
    logic [AW-1:0] in_addr;
    logic          in_first;
    logic          in_last;
    logic [DW-1:0] in_data;

    logic          ram_re;
    logic [AW-1:0] ram_ra;
    logic [DW-1:0] ram_dout;
    logic          ram_we;
    logic [AW-1:0] ram_wa;
    logic [DW-1:0] ram_di;

    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [AW-1:0] out_addr;
    logic [31:0]   sat_cnt;

    modport slave (
        input  in_valid, in_addr, in_first, in_last, in_data, ram_dout, out_ready,
        output in_ready, ram_re, ram_ra, ram_we, ram_wa, ram_di,
               out_valid, out_data, out_addr, sat_cnt
    );

    modport master (
        output in_valid, in_addr, in_first, in_last, in_data, ram_dout, out_ready,
        input  in_ready, ram_re, ram_ra, ram_we, ram_wa, ram_di,
               out_valid, out_data, out_addr, sat_cnt
    );
endinterface

// File: rtl/cacc_accu_rmw.sv
// Seeds or accumulates 16x34-bit signed partial sums into the accumulator RAM
// with saturation, and queues completed sums in a 2-entry output FIFO.
module cacc_accu_rmw #(
    parameter int LANES  = 16,
    parameter int LANE_W = 34,
    parameter int AW     = 5
) (
    input  logic           clk,
    input  logic           rst,
    cacc_accu_rmw_if.slave acc
);
    localparam int DW = LANES * LANE_W;
    localparam int CW = $clog2(LANES + 1);

    function automatic logic signed [LANE_W-1:0] sat_add(
        input  logic signed [LANE_W-1:0] a,
        input  logic signed [LANE_W-1:0] b,
        output logic                     clipped
    );
        logic signed [LANE_W:0] wide;
        wide    = {a[LANE_W-1], a} + {b[LANE_W-1], b};
        clipped = wide[LANE_W] ^ wide[LANE_W-1];
        if (!clipped)
            sat_add = wide[LANE_W-1:0];
        else if (wide[LANE_W])
            sat_add = {1'b1, {(LANE_W-1){1'b0}}};
        else
            sat_add = {1'b0, {(LANE_W-1){1'b1}}};
    endfunction

    logic          accept_p0;
    logic          vld_p1_q;
    logic          first_p1_q;
    logic          last_p1_q;
    logic [AW-1:0] addr_p1_q;
    logic [DW-1:0] data_p1_q;

    logic [DW-1:0] sum_p1;
    logic [CW-1:0] nsat_p1;
    logic          push_p1;

    logic [DW-1:0] fdata_q [2];
    logic [AW-1:0] faddr_q [2];
    logic          wptr_q, rptr_q;
    logic [1:0]    cnt_q, cnt_d;
    logic          pop;

    logic [31:0]   sat_cnt_q, sat_cnt_d;
    logic [32:0]   sat_sum;

    // Stage 0: accept beat, issue RAM read for accumulating beats
    assign acc.in_ready = ~rst & ((cnt_q + {1'b0, push_p1}) < 2'd2);
    assign accept_p0    = acc.in_valid & acc.in_ready;
    assign acc.ram_re   = accept_p0 & ~acc.in_first;
    assign acc.ram_ra   = acc.ram_re ? acc.in_addr : '0;

    always_ff @(posedge clk) begin
        if (rst)
            vld_p1_q <= 1'b0;
        else
            vld_p1_q <= accept_p0;
    end

    always_ff @(posedge clk) begin
        if (accept_p0) begin
            first_p1_q <= acc.in_first;
            last_p1_q  <= acc.in_last;
            addr_p1_q  <= acc.in_addr;
            data_p1_q  <= acc.in_data;
        end
    end

    // Stage 1: saturating add against RAM data (write-through covers same-address back-to-back)
    always_comb begin
        logic signed [LANE_W-1:0] lane_in, lane_ram, lane_sum;
        logic                     clip;
        sum_p1  = '0;
        nsat_p1 = '0;
        for (int k = 0; k < LANES; k++) begin
            lane_in  = data_p1_q[k*LANE_W +: LANE_W];
            lane_ram = acc.ram_dout[k*LANE_W +: LANE_W];
            clip     = 1'b0;
            if (first_p1_q)
                lane_sum = lane_in;
            else
                lane_sum = sat_add(lane_ram, lane_in, clip);
            sum_p1[k*LANE_W +: LANE_W] = lane_sum;
            nsat_p1 = nsat_p1 + {{(CW-1){1'b0}}, clip};
        end
    end

    assign acc.ram_we = vld_p1_q & ~rst;
    assign acc.ram_wa = acc.ram_we ? addr_p1_q : '0;
    assign acc.ram_di = acc.ram_we ? sum_p1 : '0;

    assign sat_sum = {1'b0, sat_cnt_q} + {{(33-CW){1'b0}}, nsat_p1};

    always_comb begin
        sat_cnt_d = sat_cnt_q;
        if (vld_p1_q && !first_p1_q)
            sat_cnt_d = sat_sum[32] ? 32'hFFFF_FFFF : sat_sum[31:0];
    end

    always_ff @(posedge clk) begin
        if (rst)
            sat_cnt_q <= '0;
        else
            sat_cnt_q <= sat_cnt_d;
    end

    assign acc.sat_cnt = rst ? '0 : sat_cnt_q;

    // Output FIFO: push completed sums, pop on downstream accept
    assign push_p1 = vld_p1_q & last_p1_q;
    assign pop     = (cnt_q != 2'd0) & acc.out_ready;
    assign cnt_d   = cnt_q + {1'b0, push_p1} - {1'b0, pop};

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= 1'b0;
            rptr_q <= 1'b0;
            cnt_q  <= 2'd0;
        end else begin
            if (push_p1)
                wptr_q <= ~wptr_q;
            if (pop)
                rptr_q <= ~rptr_q;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_p1) begin
            fdata_q[wptr_q] <= sum_p1;
            faddr_q[wptr_q] <= addr_p1_q;
        end
    end

    assign acc.out_valid = ~rst & (cnt_q != 2'd0);
    assign acc.out_data  = acc.out_valid ? fdata_q[rptr_q] : '0;
    assign acc.out_addr  = acc.out_valid ? faddr_q[rptr_q] : '0;
endmodule

// File: tb/tb_cacc_accu_rmw.sv
// Directed bench for cacc_accu_rmw with a behavioural write-through RAM model.
module tb_cacc_accu_rmw;
    localparam int LANES = 16;
    localparam int LW    = 34;
    localparam int AW    = 5;
    localparam int DW    = LANES * LW;
    localparam longint SMAX = 64'sd8589934591;
    localparam longint SMIN = -64'sd8589934592;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cacc_accu_rmw_if #(.LANES(LANES), .LANE_W(LW), .AW(AW)) bus ();

    cacc_accu_rmw #(.LANES(LANES), .LANE_W(LW), .AW(AW)) dut (
        .clk (clk),
        .rst (rst),
        .acc (bus)
    );

    logic [DW-1:0] mem [32];
    int            byp = 0;

    always @(posedge clk) begin
        if (bus.ram_re) begin
            if (bus.ram_we && bus.ram_wa == bus.ram_ra) begin
                bus.ram_dout <= bus.ram_di;
                byp <= byp + 1;
            end else begin
                bus.ram_dout <= mem[bus.ram_ra];
            end
        end
        if (bus.ram_we)
            mem[bus.ram_wa] <= bus.ram_di;
    end

    logic [AW+DW-1:0] oq [$];
    always @(negedge clk)
        if (bus.out_valid && bus.out_ready)
            oq.push_back({bus.out_addr, bus.out_data});

    int total = 0;
    int bad   = 0;

    function automatic logic [DW-1:0] rep(input longint v);
        logic signed [LW-1:0] x;
        logic [DW-1:0]        r;
        x = LW'(v);
        for (int k = 0; k < LANES; k++)
            r[k*LW +: LW] = x;
        return r;
    endfunction

    function automatic logic [DW-1:0] lv(input longint a0, input longint a1, input longint a2);
        logic [DW-1:0] r;
        r = '0;
        r[0*LW +: LW] = LW'(a0);
        r[1*LW +: LW] = LW'(a1);
        r[2*LW +: LW] = LW'(a2);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [AW-1:0] a, input logic f, input logic l, input logic [DW-1:0] d);
        int n;
        n = 0;
        bus.in_valid = 1'b1;
        bus.in_addr  = a;
        bus.in_first = f;
        bus.in_last  = l;
        bus.in_data  = d;
        while (!bus.in_ready && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!bus.in_ready) begin
            total++;
            bad++;
            $error("FAIL send_timeout observed=in_ready_low expected=accept addr=%0d", a);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic expect_out(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] d);
        int n;
        logic [AW+DW-1:0] e;
        n = 0;
        while (oq.size() == 0 && n < 30) begin
            @(negedge clk);
            n++;
        end
        if (oq.size() == 0) begin
            total++;
            bad++;
            $error("FAIL %s observed=no_output expected=addr_%0d", tag, a);
        end else begin
            e = oq.pop_front();
            chk({tag, "_addr"}, DW'(e[AW+DW-1:DW]), DW'(a));
            chk({tag, "_data"}, e[DW-1:0], d);
        end
    endtask

    initial begin
        int byp0;
        for (int i = 0; i < 32; i++)
            mem[i] = '0;
        bus.ram_dout  = '0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_addr   = '0;
        bus.in_first  = 1'b0;
        bus.in_last   = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", DW'(bus.in_ready), DW'(0));
        chk("rst_out_valid", DW'(bus.out_valid), DW'(0));
        chk("rst_ram_re", DW'(bus.ram_re), DW'(0));
        chk("rst_ram_we", DW'(bus.ram_we), DW'(0));
        chk("rst_sat_cnt", DW'(bus.sat_cnt), DW'(0));
        bus.in_valid = 1'b0;
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", DW'(bus.in_ready), DW'(1));
        @(posedge clk);
        #1;

        // Seed then accumulate: 5 + 7 - 2 = 10
        send(5'd3, 1'b1, 1'b0, rep(5));
        send(5'd3, 1'b0, 1'b0, rep(7));
        send(5'd3, 1'b0, 1'b1, rep(-2));
        chk("lat_t1_out_valid", DW'(bus.out_valid), DW'(0));
        @(posedge clk);
        #1;
        chk("lat_t2_out_valid", DW'(bus.out_valid), DW'(1));
        expect_out("seed_acc", 5'd3, rep(10));
        chk("ram3", mem[3], rep(10));

        // Back-to-back same address through the write-through bypass
        byp0 = byp;
        send(5'd0, 1'b1, 1'b0, rep(1));
        send(5'd0, 1'b0, 1'b0, rep(1));
        send(5'd0, 1'b0, 1'b1, rep(1));
        expect_out("b2b", 5'd0, rep(3));
        chk("b2b_bypass_hits", DW'(byp - byp0 >= 2), DW'(1));
        chk("b2b_sat_cnt", DW'(bus.sat_cnt), DW'(0));

        // Saturation at both ends, lane 2 stays in range
        send(5'd7, 1'b1, 1'b1, lv(SMAX, SMIN, -3));
        send(5'd7, 1'b0, 1'b1, lv(1, -1, 5));
        expect_out("sat_seed", 5'd7, lv(SMAX, SMIN, -3));
        expect_out("sat_acc", 5'd7, lv(SMAX, SMIN, 2));
        chk("sat_cnt", DW'(bus.sat_cnt), DW'(2));

        // Backpressure: two last beats fill the FIFO, third waits
        bus.out_ready = 1'b0;
        send(5'd10, 1'b1, 1'b1, rep(1));
        send(5'd11, 1'b1, 1'b1, rep(2));
        chk("bp_in_ready_low", DW'(bus.in_ready), DW'(0));
        repeat (3) @(posedge clk);
        #1;
        chk("bp_in_ready_hold", DW'(bus.in_ready), DW'(0));
        chk("bp_out_valid", DW'(bus.out_valid), DW'(1));
        chk("bp_head_addr", DW'(bus.out_addr), DW'(10));
        chk("bp_head_data", bus.out_data, rep(1));
        bus.out_ready = 1'b1;
        send(5'd12, 1'b1, 1'b1, rep(3));
        expect_out("bp_o0", 5'd10, rep(1));
        expect_out("bp_o1", 5'd11, rep(2));
        expect_out("bp_o2", 5'd12, rep(3));
        @(posedge clk);
        #1;
        chk("bp_in_ready_back", DW'(bus.in_ready), DW'(1));

        // Reset on the cycle after accepting a last beat
        send(5'd5, 1'b1, 1'b1, rep(9));
        rst = 1'b1;
        #1;
        chk("mid_rst_in_ready", DW'(bus.in_ready), DW'(0));
        chk("mid_rst_ram_we", DW'(bus.ram_we), DW'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("mid_rst_out_valid", DW'(bus.out_valid), DW'(0));
        chk("mid_rst_sat_cnt", DW'(bus.sat_cnt), DW'(0));
        chk("mid_rst_in_ready_back", DW'(bus.in_ready), DW'(1));
        repeat (5) @(posedge clk);
        #1;
        chk("mid_rst_no_output", DW'(oq.size()), DW'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
